// File: rtl/sprite_linebuf_pp.sv
// Ping-pong sprite line buffer: the draw engine merges pixels into the back bank
// while the video side reads, then clears, the front bank.
module sprite_linebuf_pp #(
  parameter int              PIX_W      = 8,
  parameter int              TRANS_BITS = 3,
  parameter int              XW         = 8,
  parameter int              LINE_W     = 256,
  parameter logic [XW-1:0]   X_OFFSET   = 8'hFE,
  parameter int              PRIORITY   = 0
) (
  input  logic             grpclk1,
  input  logic             reset,
  input  logic             pix_en,
  input  logic             line_start,
  input  logic             flip,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [XW-1:0]    wr_x,
  input  logic [PIX_W-1:0] wr_pix,
  output logic [PIX_W-1:0] pix_out,
  output logic             pix_opaque,
  output logic             front_bank,
  output logic             init_done
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_RD, S_WR} state_t;

  localparam logic [XW-1:0] LAST_X = XW'(LINE_W - 1);
  localparam logic [XW:0]   DEPTH  = (XW + 1)'(LINE_W);

  state_t             state_q, state_d;
  logic [XW-1:0]      init_cnt_q, init_cnt_d;
  logic [XW-1:0]      rd_x_q, rd_x_d;
  logic               front_q;
  logic [XW-1:0]      wa_q;
  logic [PIX_W-1:0]   pix_q;
  logic               tgt_q;
  logic               rd_vld_q;
  logic               rd_bank_q;
  logic [PIX_W-1:0]   pix_out_q;
  logic               opaque_q;

  logic                  init_act, draw_busy, accept, swap, rd_en, draw_we;
  logic [TRANS_BITS-1:0] stored_val;
  logic [PIX_W-1:0]      rd_pix;
  logic [1:0]            ram_we;
  logic [1:0][XW-1:0]    ram_addr;
  logic [1:0][PIX_W-1:0] ram_wd;
  logic [1:0][PIX_W-1:0] ram_rd;

  assign init_act  = (state_q == S_INIT);
  assign draw_busy = (state_q == S_RD) || (state_q == S_WR);
  assign accept    = (state_q == S_IDLE) && wr_valid;
  assign swap      = line_start && !init_act;
  // A transaction still finishing into a bank that just became front owns its
  // port, so readout skips that cycle rather than losing the draw.
  assign rd_en     = pix_en && !line_start && !init_act && !(draw_busy && (tgt_q == front_q));

  assign stored_val = tgt_q ? ram_rd[1][TRANS_BITS-1:0] : ram_rd[0][TRANS_BITS-1:0];
  assign draw_we    = (state_q == S_WR) && ({1'b0, wa_q} < DEPTH)
                      && (|pix_q[TRANS_BITS-1:0])
                      && ((PRIORITY != 0) || (stored_val == '0));

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_bank
    logic             draw_own;
    logic [PIX_W-1:0] mem_q [LINE_W];
    logic [PIX_W-1:0] rd_q;

    assign draw_own     = draw_busy && (tgt_q == 1'(gi));
    assign ram_addr[gi] = init_act ? init_cnt_q : (draw_own ? wa_q : rd_x_q);
    assign ram_we[gi]   = init_act || (draw_own ? draw_we : ((front_q == 1'(gi)) && rd_en));
    assign ram_wd[gi]   = (draw_own && !init_act) ? pix_q : '0;
    assign ram_rd[gi]   = rd_q;

    always_ff @(posedge grpclk1) begin
      if (ram_we[gi]) mem_q[ram_addr[gi]] <= ram_wd[gi];
      rd_q <= mem_q[ram_addr[gi]];
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    rd_x_d     = rd_x_q;
    wr_ready   = 1'b0;
    unique case (state_q)
      S_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LAST_X) begin
          state_d    = S_IDLE;
          init_cnt_d = '0;
        end
      end
      S_IDLE: begin
        wr_ready = 1'b1;
        if (wr_valid) state_d = (PRIORITY != 0) ? S_WR : S_RD;
      end
      S_RD:    state_d = S_WR;
      S_WR:    state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
    if (swap) begin
      rd_x_d = flip ? LAST_X : '0;
    end else if (rd_en) begin
      if (flip) rd_x_d = (rd_x_q == '0) ? LAST_X : rd_x_q - 1'b1;
      else      rd_x_d = (rd_x_q == LAST_X) ? '0 : rd_x_q + 1'b1;
    end
  end

  assign rd_pix = rd_bank_q ? ram_rd[1] : ram_rd[0];

  always_ff @(posedge grpclk1) begin
    if (reset) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      rd_x_q     <= '0;
      front_q    <= 1'b0;
      wa_q       <= '0;
      pix_q      <= '0;
      tgt_q      <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_bank_q  <= 1'b0;
      pix_out_q  <= '0;
      opaque_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rd_x_q     <= rd_x_d;
      if (swap) front_q <= ~front_q;
      rd_vld_q   <= rd_en;
      rd_bank_q  <= front_q;
      if (rd_vld_q) begin
        pix_out_q <= rd_pix;
        opaque_q  <= |rd_pix[TRANS_BITS-1:0];
      end
      if (accept) begin
        wa_q  <= wr_x + X_OFFSET;
        pix_q <= wr_pix;
        tgt_q <= ~front_q;
      end
    end
  end

  assign pix_out    = pix_out_q;
  assign pix_opaque = opaque_q;
  assign front_bank = front_q;
  assign init_done  = !init_act;

endmodule

// File: tb/tb_sprite_linebuf_pp.sv
// Scoreboard bench: two instances (first-wins and last-wins priority) share stimulus;
// readout expectations are queued at pix_en time and checked two clocks later.
module tb_sprite_linebuf_pp;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_en = 1'b0;
  logic       line_start = 1'b0;
  logic       flip = 1'b0;
  logic       wv0 = 1'b0, wv1 = 1'b0;
  logic [7:0] wr_x = '0, wr_pix = '0;
  logic       rdy0, rdy1, op0, op1, fb0, fb1, id0, id1;
  logic [7:0] pix0, pix1;

  int checks = 0;
  int failures = 0;

  logic [15:0] sbq[$];
  logic [7:0]  exp0 [256];
  logic [7:0]  exp1 [256];
  int          pos = 0;
  logic        fb = 1'b0;
  logic        d1 = 1'b0, d2 = 1'b0;
  logic [15:0] mon_e;

  always #5 clk = ~clk;

  sprite_linebuf_pp #(.PRIORITY(0)) dut0 (
    .grpclk1(clk), .reset(reset), .pix_en(pix_en), .line_start(line_start), .flip(flip),
    .wr_valid(wv0), .wr_ready(rdy0), .wr_x(wr_x), .wr_pix(wr_pix),
    .pix_out(pix0), .pix_opaque(op0), .front_bank(fb0), .init_done(id0));

  sprite_linebuf_pp #(.PRIORITY(1)) dut1 (
    .grpclk1(clk), .reset(reset), .pix_en(pix_en), .line_start(line_start), .flip(flip),
    .wr_valid(wv1), .wr_ready(rdy1), .wr_x(wr_x), .wr_pix(wr_pix),
    .pix_out(pix1), .pix_opaque(op1), .front_bank(fb1), .init_done(id1));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Readout delay line: an accepted pix_en shows up on pix_out two edges later.
  always @(posedge clk) begin
    if (reset) begin
      d1 <= 1'b0;
      d2 <= 1'b0;
    end else begin
      d1 <= pix_en && !line_start;
      d2 <= d1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (d2) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow got=pixel exp=none");
      end else begin
        mon_e = sbq.pop_front();
        chk("pix_p0", {23'd0, op0, pix0}, {23'd0, |mon_e[10:8], mon_e[15:8]});
        chk("pix_p1", {23'd0, op1, pix1}, {23'd0, |mon_e[2:0], mon_e[7:0]});
      end
    end
  end

  task automatic clear_exp();
    for (int i = 0; i < 256; i++) begin
      exp0[i] = '0;
      exp1[i] = '0;
    end
  endtask

  task automatic wait_init();
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      if (i == 255) begin
        chk("init_done_255_p0", {31'd0, id0}, 32'd0);
        chk("init_done_255_p1", {31'd0, id1}, 32'd0);
      end
      if (i == 256) begin
        chk("init_done_256_p0", {31'd0, id0}, 32'd1);
        chk("init_done_256_p1", {31'd0, id1}, 32'd1);
        chk("wr_ready_p0", {31'd0, rdy0}, 32'd1);
        chk("wr_ready_p1", {31'd0, rdy1}, 32'd1);
      end
    end
    $display("init sweep complete init_done=%0d/%0d", id0, id1);
  endtask

  task automatic do_reset();
    reset = 1'b1; pix_en = 1'b0; line_start = 1'b0; wv0 = 1'b0; wv1 = 1'b0;
    @(negedge clk);
    chk("rst_pix_p0", {23'd0, op0, pix0}, 32'd0);
    chk("rst_pix_p1", {23'd0, op1, pix1}, 32'd0);
    chk("rst_ctl_p0", {28'd0, id0, rdy0, fb0}, 32'd0);
    chk("rst_ctl_p1", {28'd0, id1, rdy1, fb1}, 32'd0);
    reset = 1'b0;
    sbq.delete();
    clear_exp();
    pos = 0;
    fb = 1'b0;
    wait_init();
  endtask

  task automatic do_ls();
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    fb = ~fb;
    pos = flip ? 255 : 0;
    chk("front_bank_p0", {31'd0, fb0}, {31'd0, fb});
    chk("front_bank_p1", {31'd0, fb1}, {31'd0, fb});
    $display("line_start flip=%0d front_bank=%0d", flip, fb);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(rdy0 && rdy1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      failures++;
      $display("FAIL idle_timeout got=busy exp=idle");
    end
  endtask

  task automatic draw(input logic [7:0] x, input logic [7:0] p, input bit ls_after);
    int  n = 0;
    logic a0, a1;
    wr_x = x; wr_pix = p; wv0 = 1'b1; wv1 = 1'b1;
    while ((wv0 || wv1) && n < 20) begin
      a0 = wv0 && rdy0;
      a1 = wv1 && rdy1;
      @(negedge clk);
      if (a0) wv0 = 1'b0;
      if (a1) wv1 = 1'b0;
      n++;
    end
    checks++;
    if (n >= 20) begin
      failures++;
      $display("FAIL accept_timeout got=no_accept exp=accept");
      wv0 = 1'b0; wv1 = 1'b0;
    end
    $display("draw x=%h pix=%h", x, p);
    if (ls_after) do_ls();
    wait_idle();
  endtask

  task automatic read_line(input int n);
    for (int i = 0; i < n; i++) begin
      pix_en = 1'b1;
      sbq.push_back({exp0[pos], exp1[pos]});
      exp0[pos] = '0;
      exp1[pos] = '0;
      if (flip) pos = (pos == 0) ? 255 : pos - 1;
      else      pos = (pos == 255) ? 0 : pos + 1;
      @(negedge clk);
    end
    pix_en = 1'b0;
    repeat (3) @(negedge clk);
    $display("read %0d pixels flip=%0d", n, flip);
  endtask

  initial begin
    clear_exp();
    do_reset();
    read_line(256);

    // Priority: first-wins keeps 0x2D, last-wins keeps 0x15; transparent 0x28 ignored.
    draw(8'h12, 8'h2D, 1'b0);
    draw(8'h12, 8'h15, 1'b0);
    draw(8'h12, 8'h28, 1'b0);
    draw(8'h01, 8'h03, 1'b0);
    do_ls();
    exp0[8'h10] = 8'h2D; exp1[8'h10] = 8'h15;
    exp0[8'hFF] = 8'h03; exp1[8'hFF] = 8'h03;
    read_line(256);

    // Flipped readout: pixel at 0x00 comes out last; a wrapped re-read is all clear.
    draw(8'h02, 8'h07, 1'b0);
    flip = 1'b1;
    do_ls();
    exp0[8'h00] = 8'h07; exp1[8'h00] = 8'h07;
    read_line(256);
    read_line(256);
    flip = 1'b0;

    // Swap one clock after accept: the write completes into the bank now displayed.
    draw(8'h22, 8'h11, 1'b1);
    draw(8'h32, 8'h06, 1'b0);
    exp0[8'h20] = 8'h11; exp1[8'h20] = 8'h11;
    read_line(256);
    do_ls();
    exp0[8'h30] = 8'h06; exp1[8'h30] = 8'h06;
    read_line(256);

    // Reset mid-line with stored data.
    draw(8'h21, 8'h3C, 1'b0);
    draw(8'h42, 8'h05, 1'b0);
    do_ls();
    exp0[8'h1F] = 8'h3C; exp1[8'h1F] = 8'h3C;
    read_line(32);
    chk("hold_pix_p0", {24'd0, pix0}, 32'h3C);
    chk("hold_pix_p1", {24'd0, pix1}, 32'h3C);
    do_reset();
    do_ls();
    read_line(256);

    chk("sb_empty", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
